// File: rtl/sm4_sbox_sched_pkg.sv
// ============================================================================
// Module   : sm4_pkg
// Purpose  : Shared constants, state encoding and byte helper for the SM4
//            S-box scheduler. Honours SM4_SBOX_PIPE_EN (registered S-box).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package sm4_pkg;

    localparam int SM4_WORD_W = 32;
    localparam int SM4_BYTE_W = 8;
    localparam int SM4_NBYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } sm4_state_e;

    // A registered S-box needs one extra SUB cycle to drain its output stage.
`ifdef SM4_SBOX_PIPE_EN
    localparam int SUB_CYCLES = 5;
`else
    localparam int SUB_CYCLES = 4;
`endif

    localparam int CNT_W = $clog2(SUB_CYCLES);

    function automatic logic [SM4_BYTE_W-1:0] sm4_byte(input logic [SM4_WORD_W-1:0] w,
                                                       input logic [1:0] k);
        return w[SM4_BYTE_W*(SM4_NBYTES-1-int'(k)) +: SM4_BYTE_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sm4_sbox_sched_if.sv
// ============================================================================
// Module   : sm4_sbox_sched_if
// Purpose  : Request/response bundle between requesters and the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface sm4_sbox_sched_if
    import sm4_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) ();

    logic [NREQ-1:0]            req_valid;
    logic [NREQ*SM4_WORD_W-1:0] req_data;
    logic [NREQ-1:0]            req_ready;
    logic                       rsp_valid;
    logic [SM4_WORD_W-1:0]      rsp_data;
    logic [IDW-1:0]             rsp_id;
    logic                       rsp_ready;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface

`default_nettype wire

// File: rtl/sm4_sbox_sched_rr_arb.sv
// ============================================================================
// Module   : sm4_rr_arb
// Purpose  : Combinational round-robin grant, searching upward from ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sm4_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int             pos;
    logic [IDW-1:0] sel;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        sel   = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            sel = IDW'(pos);
            if (!any && valid[sel]) begin
                any        = 1'b1;
                grant[sel] = 1'b1;
                idx        = sel;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sm4_sbox_sched.sv
// ============================================================================
// Module   : sm4_sbox_sched
// Purpose  : Round-robin scheduler sharing one 8-bit SM4 S-box across NREQ
//            tau requesters. Option macro: SM4_SBOX_PIPE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sm4_sbox_sched
    import sm4_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    sm4_sbox_sched_if.slave       bus,
    output logic [SM4_BYTE_W-1:0] sbox_in,
    input  logic [SM4_BYTE_W-1:0] sbox_out,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SUB  = SUB;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [SM4_WORD_W-1:0] word;
    logic [SM4_WORD_W-1:0] result;
    logic [IDW-1:0]        id;
    logic [IDW-1:0]        ptr;

    logic [NREQ-1:0]       grant;
    logic [IDW-1:0]        gidx;
    logic                  any;

    logic                  pres_en;
    logic                  cap_en;
    logic [1:0]            pres_idx;
    logic [1:0]            cap_idx;

    sm4_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .valid (bus.req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (any)
    );

    assign pres_idx = cnt[1:0];

    // With a registered S-box the result for byte k arrives one cycle later.
`ifdef SM4_SBOX_PIPE_EN
    assign pres_en = (cnt != CNT_W'(SUB_CYCLES-1));
    assign cap_en  = (cnt != '0);
    assign cap_idx = 2'(cnt - 1'b1);
`else
    assign pres_en = 1'b1;
    assign cap_en  = 1'b1;
    assign cap_idx = cnt[1:0];
`endif

    assign sbox_in       = (state == ST_SUB && pres_en) ? sm4_byte(word, pres_idx) : '0;
    assign bus.req_ready = (state == ST_IDLE) ? grant : '0;
    assign bus.rsp_valid = (state == ST_DONE);
    assign bus.rsp_data  = result;
    assign bus.rsp_id    = id;
    assign busy          = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            word   <= '0;
            result <= '0;
            id     <= '0;
            ptr    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        word  <= bus.req_data[SM4_WORD_W*int'(gidx) +: SM4_WORD_W];
                        id    <= gidx;
                        cnt   <= '0;
                        ptr   <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
                        state <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    if (cap_en) begin
                        result[SM4_BYTE_W*(SM4_NBYTES-1-int'(cap_idx)) +: SM4_BYTE_W] <= sbox_out;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(SUB_CYCLES-1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sm4_sbox_sched.sv
// ============================================================================
// Module   : tb_sm4_sbox_sched
// Purpose  : Scoreboard bench for sm4_sbox_sched with an SM4 S-box model
//            (registered when SM4_SBOX_PIPE_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sm4_sbox_sched;
    import sm4_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
`ifdef SM4_SBOX_PIPE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 5;
`endif
    localparam int SPACING = SUB_CYCLES + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sbox_in;
    logic [7:0] sbox_out;
    logic       busy;

    always #5 clk = ~clk;

    sm4_sbox_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    sm4_sbox_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .sbox_in  (sbox_in),
        .sbox_out (sbox_out),
        .busy     (busy)
    );

    logic [7:0] sbox_tbl [256] = '{
        8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
        8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
        8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
        8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
        8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
        8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
        8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
        8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
        8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
        8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
        8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
        8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
        8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
        8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
        8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
    };

`ifdef SM4_SBOX_PIPE_EN
    logic [7:0] sbox_q = 8'h00;
    always @(posedge clk) sbox_q <= sbox_tbl[sbox_in];
    assign sbox_out = sbox_q;
`else
    assign sbox_out = sbox_tbl[sbox_in];
`endif

    function automatic logic [31:0] tau(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = sbox_tbl[w[8*k +: 8]];
        end
        return r;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    data;
    } exp_t;

    exp_t exp_q [$];
    int   grant_log [$];
    int   gcyc_log [$];
    int   ngrant    = 0;
    int   last_gcyc = 0;
    int   cyc       = 0;

    logic            prev_valid = 1'b0;
    logic            prev_rdy   = 1'b0;
    logic [31:0]     prev_data  = '0;
    logic [IDW-1:0]  prev_id    = '0;
    logic [NREQ-1:0] prev_req_ready = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: grant properties, latency, stall stability and scoreboard pops.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid     <= 1'b0;
            prev_rdy       <= 1'b0;
            prev_req_ready <= '0;
        end else begin
            if (bus.req_ready != '0) begin
                check("rdy_onehot", 64'($onehot(bus.req_ready)), 64'd1);
                check("rdy_width", 64'(prev_req_ready), 64'd0);
                check("rdy_idle", 64'(busy), 64'd0);
                for (int i = 0; i < NREQ; i++) begin
                    if (bus.req_ready[i]) grant_log.push_back(i);
                end
                gcyc_log.push_back(cyc);
                last_gcyc = cyc;
                ngrant++;
            end
            if (bus.rsp_valid && !prev_valid) begin
                check("latency", 64'(cyc - last_gcyc), 64'(LAT));
            end
            if (bus.rsp_valid && prev_valid && !prev_rdy) begin
                check("stall_data", 64'(bus.rsp_data), 64'(prev_data));
                check("stall_id", 64'(bus.rsp_id), 64'(prev_id));
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_spurious", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                    check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                end
            end
            prev_valid     <= bus.rsp_valid;
            prev_rdy       <= bus.rsp_ready;
            prev_data      <= bus.rsp_data;
            prev_id        <= bus.rsp_id;
            prev_req_ready <= bus.req_ready;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input int id, input logic [31:0] data);
        exp_t e;
        e.id   = IDW'(id);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_req(input int id, input logic [31:0] word, input logic [31:0] exp);
        int t;
        push_exp(id, exp);
        @(posedge clk);
        #1;
        bus.req_data[32*id +: 32] = word;
        bus.req_valid[id]         = 1'b1;
        t = 0;
        do begin
            tick();
            t++;
        end while (!bus.req_ready[id] && t < 100);
        if (!bus.req_ready[id]) check("grant_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) check("drain_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int t;
        int base;
        int gl_base;
        logic [31:0] rr_w [4];
        logic [7:0]  exp_b;

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;
        rr_w[0] = 32'h01234567;
        rr_w[1] = 32'h89ABCDEF;
        rr_w[2] = 32'hDEADBEEF;
        rr_w[3] = 32'h0F1E2D3C;

        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        check("rst_sbox_in", 64'(sbox_in), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single request, MSB-first byte walk.
        do_req(0, 32'h00010203, 32'hD690E9FE);
        for (int k = 0; k < SUB_CYCLES; k++) begin
            tick();
            exp_b = (k < 4) ? 8'(k) : 8'h00;
            check("sub_sbox_in", 64'(sbox_in), 64'(exp_b));
        end
        drain();

        do_req(2, 32'hFFFFFFFF, 32'h48484848);
        drain();
        do_req(3, 32'h10000000, 32'h2BD6D6D6);
        drain();

        // Reset in the middle of SUB (cnt=2).
        do_req(1, 32'h11223344, tau(32'h11223344));
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_rst_sbox_in", 64'(sbox_in), 64'h33);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("mid_rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("mid_rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        check("mid_rst_sbox_in", 64'(sbox_in), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // All requesters valid after reset: pointer restarts at 0.
        for (int k = 0; k < 5; k++) push_exp(k % 4, tau(rr_w[k % 4]));
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) bus.req_data[32*i +: 32] = rr_w[i];
        base    = ngrant;
        gl_base = grant_log.size();
        bus.req_valid = '1;
        t = 0;
        while (ngrant < base + 5 && t < 200) begin
            tick();
            t++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        check("rr_count", 64'(ngrant - base), 64'd5);
        if (grant_log.size() >= gl_base + 5) begin
            for (int k = 0; k < 5; k++) begin
                check("rr_order", 64'(grant_log[gl_base + k]), 64'(k % 4));
            end
            for (int k = 1; k < 5; k++) begin
                check("rr_spacing", 64'(gcyc_log[gl_base + k] - gcyc_log[gl_base + k - 1]),
                      64'(SPACING));
            end
        end
        drain();

        // Backpressure in DONE with a competing requester waiting.
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        do_req(2, 32'hA5A55A5A, tau(32'hA5A55A5A));
        t = 0;
        while (!bus.rsp_valid && t < 50) begin
            tick();
            t++;
        end
        check("bp_reach_done", 64'(bus.rsp_valid), 64'd1);
        push_exp(0, tau(32'h5A5AA5A5));
        bus.req_data[31:0] = 32'h5A5AA5A5;
        bus.req_valid[0]   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_busy", 64'(busy), 64'd1);
            check("bp_no_grant", 64'(bus.req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        check("bp_idle_busy", 64'(busy), 64'd0);
        check("bp_regrant", 64'(bus.req_ready), 64'b0001);
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
